// File: rtl/axi_rx_buffer.sv
// axi_rx_buffer
//   Receive-side elastic buffer between a VALID/READY bus transmitter and a
//   local sink. Words are stored in a DEPTH-entry circular buffer. READY is
//   registered and never depends on VALID in the same cycle. A sticky
//   proto_err flags a transmitter that drops VALID or changes xDATA while
//   stalled.
//
//   state | meaning
//   ------+------------------------------------------
//   EMPTY | rx_count == 0, nothing for the sink
//   PART  | 0 < rx_count < DEPTH
//   FULL  | rx_count == DEPTH, READY held low
//
// Ports
//   ACLK      in   clock, rising edge
//   ARESETn   in   synchronous active-low reset
//   VALID     in   bus valid from transmitter
//   xDATA     in   bus payload [WIDTH]
//   READY     out  bus ready to transmitter (registered)
//   rx_valid  out  word available to local sink
//   rx_data   out  head-of-buffer word, 0 when empty
//   rx_ready  in   sink accepts rx_data this cycle
//   rx_count  out  occupancy [$clog2(DEPTH)+1]
//   proto_err out  sticky bus-protocol violation
module axi_rx_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic                       VALID,
    input  logic [WIDTH-1:0]           xDATA,
    output logic                       READY,
    output logic                       rx_valid,
    output logic [WIDTH-1:0]           rx_data,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH):0]     rx_count,
    output logic                       proto_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       next_count;
    logic                push;
    logic                pop;
    logic                stall_q;
    logic [WIDTH-1:0]    data_q;

    assign push     = VALID & READY;
    assign pop      = rx_valid & rx_ready;
    assign rx_valid = (rx_count != '0);
    // Gate the read so an unwritten entry can never leak X to the sink.
    assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

    always_comb begin
        next_count = rx_count;
        case ({push, pop})
            2'b10:   next_count = rx_count + CW'(1);
            2'b01:   next_count = rx_count - CW'(1);
            default: next_count = rx_count;
        endcase
    end

    // Storage is not reset; rx_count gating makes stale contents invisible.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= xDATA;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
            READY    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            rx_count <= next_count;
            READY    <= (next_count < FULL_CNT);
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q <= PART;
                    end
                end
                PART: begin
                    if (push && !pop && (rx_count == FULL_CNT - CW'(1))) begin
                        state_q <= FULL;
                    end else if (pop && !push && (rx_count == CW'(1))) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q <= PART;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    // A stalled transfer (VALID high, READY low) must keep VALID and xDATA
    // stable until accepted; anything else is latched as an error.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            stall_q   <= 1'b0;
            data_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            stall_q <= VALID & ~READY;
            data_q  <= xDATA;
            if (stall_q && (!VALID || (xDATA != data_q))) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rx_buffer.sv
module tb_axi_rx_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             ACLK;
    logic             ARESETn;
    logic             VALID;
    logic [WIDTH-1:0] xDATA;
    logic             READY;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;
    logic [2:0]       rx_count;
    logic             proto_err;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] S_EMPTY = 32'd0;
    localparam logic [31:0] S_PART  = 32'd1;
    localparam logic [31:0] S_FULL  = 32'd2;

    axi_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .VALID     (VALID),
        .xDATA     (xDATA),
        .READY     (READY),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_count  (rx_count),
        .proto_err (proto_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fsm_state();
        return 32'(dut.state_q);
    endfunction

    initial begin
        ARESETn  = 1'b0;
        VALID    = 1'b0;
        xDATA    = '0;
        rx_ready = 1'b0;
        tick();
        tick();

        check("rst_ready",    32'(READY),     32'd0);
        check("rst_rx_valid", 32'(rx_valid),  32'd0);
        check("rst_count",    32'(rx_count),  32'd0);
        check("rst_err",      32'(proto_err), 32'd0);
        check("rst_data",     32'(rx_data),   32'd0);
        check("rst_state",    fsm_state(),    S_EMPTY);

        // Release with VALID held: READY after edge 1, push at edge 2
        ARESETn = 1'b1;
        VALID   = 1'b1;
        xDATA   = 8'hA5;
        tick();
        check("e1_ready",    32'(READY),    32'd1);
        check("e1_rx_valid", 32'(rx_valid), 32'd0);
        check("e1_count",    32'(rx_count), 32'd0);
        tick();
        check("e2_rx_valid", 32'(rx_valid), 32'd1);
        check("e2_rx_data",  32'(rx_data),  32'hA5);
        check("e2_count",    32'(rx_count), 32'd1);
        check("e2_state",    fsm_state(),   S_PART);

        VALID    = 1'b0;
        rx_ready = 1'b1;
        tick();
        check("pop1_count", 32'(rx_count), 32'd0);
        check("pop1_valid", 32'(rx_valid), 32'd0);
        check("pop1_data",  32'(rx_data),  32'd0);
        check("pop1_state", fsm_state(),   S_EMPTY);
        // Empty pop request ignored
        tick();
        check("empty_pop_count", 32'(rx_count), 32'd0);
        rx_ready = 1'b0;

        // Fill: 0x01..0x05 back-to-back, 0x05 stalls
        VALID = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            xDATA = 8'(i);
            tick();
        end
        tick();
        check("full_count", 32'(rx_count),  32'd4);
        check("full_state", fsm_state(),    S_FULL);
        check("full_ready", 32'(READY),     32'd0);
        check("full_err",   32'(proto_err), 32'd0);
        check("full_head",  32'(rx_data),   32'h01);

        // Drain from full: 0x05 is accepted on the second edge
        rx_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k < 5) begin
                check("drain_valid", 32'(rx_valid), 32'd1);
                check("drain_data",  32'(rx_data),  32'(k + 1));
            end else begin
                check("drain_empty", 32'(rx_valid), 32'd0);
            end
            tick();
            if (k == 0) check("drain_ready_up", 32'(READY), 32'd1);
            if (k == 1) VALID = 1'b0;
        end
        check("drain_count", 32'(rx_count),  32'd0);
        check("drain_state", fsm_state(),    S_EMPTY);
        check("drain_err",   32'(proto_err), 32'd0);
        rx_ready = 1'b0;

        // Count 2 then 10 cycles of simultaneous push and pop
        VALID = 1'b1;
        xDATA = 8'h20;
        tick();
        xDATA = 8'h21;
        tick();
        check("sim_pre_count", 32'(rx_count), 32'd2);
        rx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            xDATA = 8'(8'h22 + i);
            check("sim_data", 32'(rx_data), 32'(8'h20 + i));
            tick();
            check("sim_count", 32'(rx_count), 32'd2);
            check("sim_state", fsm_state(),   S_PART);
        end
        VALID = 1'b0;
        check("sim_tail0", 32'(rx_data), 32'h2A);
        tick();
        check("sim_tail1", 32'(rx_data), 32'h2B);
        tick();
        check("sim_end_count", 32'(rx_count), 32'd0);
        check("sim_end_state", fsm_state(),   S_EMPTY);
        rx_ready = 1'b0;

        // Protocol error: data change while stalled
        VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            xDATA = 8'(8'h30 + i);
            tick();
        end
        check("perr_full_ready", 32'(READY), 32'd0);
        xDATA = 8'h10;
        tick();
        check("perr_stall_ok", 32'(proto_err), 32'd0);
        xDATA = 8'h11;
        tick();
        check("perr_set", 32'(proto_err), 32'd1);
        VALID = 1'b0;
        tick();
        tick();
        check("perr_sticky", 32'(proto_err), 32'd1);
        check("perr_data_ok", 32'(rx_data), 32'h30);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("perr_pop_count", 32'(rx_count), 32'd3);
        check("perr_pop_head",  32'(rx_data),  32'h31);
        check("perr_still",     32'(proto_err), 32'd1);

        // Reset with three words buffered
        ARESETn  = 1'b0;
        rx_ready = 1'b1;
        tick();
        check("mrst_count", 32'(rx_count),  32'd0);
        check("mrst_valid", 32'(rx_valid),  32'd0);
        check("mrst_ready", 32'(READY),     32'd0);
        check("mrst_err",   32'(proto_err), 32'd0);
        check("mrst_data",  32'(rx_data),   32'd0);
        ARESETn  = 1'b1;
        rx_ready = 1'b0;
        tick();
        check("mrst_rel_ready", 32'(READY),    32'd1);
        check("mrst_rel_count", 32'(rx_count), 32'd0);
        VALID = 1'b1;
        xDATA = 8'h77;
        tick();
        VALID = 1'b0;
        check("mrst_new_head",  32'(rx_data),  32'h77);
        check("mrst_new_count", 32'(rx_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
